// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM state encoding and the
// default gate window (1 s at 100 MHz).
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEFAULT_GATE_CYCLES = 100_000_000;

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// Synchroniser plus rising-edge detector for an asynchronous level input.
// Also usable for switch and button inputs.
module freq_meter_sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic resync,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      s_d    <= s;
    end
  end

  // During resync the delay register is reloaded from s, so whatever edge
  // is in flight in that cycle is treated as stale and not reported.
  assign rise = s & ~s_d & ~resync;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts rising edges of sig_in over GATE_CYCLES clocks
// and publishes a saturating result with a one-cycle valid pulse.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
  parameter int CNT_W       = 27,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic [CNT_W-1:0] freq_cnt,
  output logic             valid,
  output logic             ovf,
  output state_t           dbg_state
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_nxt;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_nxt;
  logic             sat;
  logic             sat_nxt;
  logic             rise;
  logic             gate_end;

  freq_meter_sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sig_in),
    .resync(state == ARM),
    .rise  (rise)
  );

  assign gate_end = (state == MEASURE) && (gate_cnt == GATE_LAST);

  // Saturating increment: an edge arriving at full scale is dropped and flagged.
  always_comb begin
    edge_nxt = edge_cnt;
    sat_nxt  = sat;
    if (rise) begin
      if (edge_cnt == CNT_MAX) sat_nxt  = 1'b1;
      else                     edge_nxt = edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ARM;
      ARM:     state_nxt = MEASURE;
      MEASURE: if (gate_end) state_nxt = DONE;
      DONE:    state_nxt = continuous ? ARM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
      freq_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        ARM: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat      <= 1'b0;
        end
        MEASURE: begin
          edge_cnt <= edge_nxt;
          sat      <= sat_nxt;
          if (gate_end) begin
            // Include an edge in the final gate cycle so DONE sees the full count.
            freq_cnt <= edge_nxt;
            ovf      <= sat_nxt;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    valid     = (state == DONE);
    dbg_state = state;
  end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter with a 100-cycle gate; a CNT_W=4 copy
// shares the inputs to exercise saturation.
module tb_freq_meter;
  import freq_meter_pkg::*;

  localparam int G = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sig_in;
  logic        start;
  logic        continuous;
  logic        busy, valid, ovf;
  logic [26:0] freq_cnt;
  state_t      dbg_state;
  logic        busy4, valid4, ovf4;
  logic [3:0]  freq4;
  state_t      dbg4;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int mode   = 0;
  int period = 10;
  bit v [65536];

  freq_meter #(.GATE_CYCLES(G), .CNT_W(27), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .continuous(continuous),
    .busy(busy), .freq_cnt(freq_cnt), .valid(valid), .ovf(ovf), .dbg_state(dbg_state)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .continuous(continuous),
    .busy(busy4), .freq_cnt(freq4), .valid(valid4), .ovf(ovf4), .dbg_state(dbg4)
  );

  always #5 clk = ~clk;

  // One clock; outputs are then stable for cycle cyc, and sig_in is driven for it.
  task automatic tick();
    bit s;
    @(posedge clk);
    #1;
    cyc++;
    case (mode)
      0:       s = 1'b0;
      1:       s = 1'b1;
      2:       s = (cyc % period) < (period / 2);
      default: s = 1'($urandom_range(0, 1));
    endcase
    sig_in = s;
    v[cyc] = s;
  endtask

  // Tick until cycle c; report how many valid pulses appeared strictly before c.
  task automatic run_to(input int c, output int pulses);
    pulses = 0;
    while (cyc < c) begin
      tick();
      if (valid && cyc < c) pulses++;
    end
  endtask

  // Reference: rising edges of sig_in over the gate window, as seen after
  // a two-flop synchroniser, for a start sampled in cycle k.
  function automatic int model_count(input int k);
    int n = 0;
    for (int m = k + 2; m <= k + G + 1; m++)
      if (v[m-2] && !v[m-3]) n++;
    return n;
  endfunction

  task automatic pulse_start(output int k);
    k = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", valid); end
    checks++; if (freq_cnt !== 27'd0) begin errors++; $display("FAIL reset_freq got=%0d exp=0", freq_cnt); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_period10();
    int k, p;
    mode = 2; period = 10;
    repeat (5) tick();
    pulse_start(k);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL p10_busy_k1 got=%0b exp=1", busy); end
    run_to(k + G + 2, p);
    checks++; if (p != 0) begin errors++; $display("FAIL p10_early_valid got=%0d exp=0", p); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL p10_valid got=%0b exp=1", valid); end
    checks++; if (freq_cnt !== 27'd10) begin errors++; $display("FAIL p10_freq got=%0d exp=10", freq_cnt); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL p10_ovf got=%0b exp=0", ovf); end
    tick();
    checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL p10_after busy=%0b valid=%0b exp 0/0", busy, valid); end
    checks++; if (freq_cnt !== 27'd10) begin errors++; $display("FAIL p10_hold got=%0d exp=10", freq_cnt); end
  endtask

  task automatic test_toggle();
    int k, p;
    mode = 2; period = 2;
    repeat (4) tick();
    pulse_start(k);
    run_to(k + G + 2, p);
    checks++; if (valid !== 1'b1 || p != 0) begin errors++; $display("FAIL tog_valid got=%0b early=%0d exp=1/0", valid, p); end
    checks++; if (freq_cnt !== 27'd50) begin errors++; $display("FAIL tog_freq got=%0d exp=50", freq_cnt); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL tog_ovf got=%0b exp=0", ovf); end
    checks++; if (freq4 !== 4'd15) begin errors++; $display("FAIL tog_freq4 got=%0d exp=15", freq4); end
    checks++; if (ovf4 !== 1'b1) begin errors++; $display("FAIL tog_ovf4 got=%0b exp=1", ovf4); end
  endtask

  task automatic test_constant();
    int k, p;
    for (int lvl = 1; lvl >= 0; lvl--) begin
      mode = lvl;
      repeat (6) tick();
      pulse_start(k);
      run_to(k + G + 2, p);
      checks++; if (valid !== 1'b1 || p != 0) begin errors++; $display("FAIL const%0d_valid got=%0b early=%0d exp=1/0", lvl, valid, p); end
      checks++; if (freq_cnt !== 27'd0 || ovf !== 1'b0) begin errors++; $display("FAIL const%0d_freq got=%0d ovf=%0b exp=0/0", lvl, freq_cnt, ovf); end
      checks++; if (freq4 !== 4'd0 || ovf4 !== 1'b0) begin errors++; $display("FAIL const%0d_freq4 got=%0d ovf=%0b exp=0/0", lvl, freq4, ovf4); end
    end
  endtask

  task automatic test_continuous();
    int k, p;
    mode = 2; period = 4;
    repeat (3) tick();
    continuous = 1'b1;
    pulse_start(k);
    for (int r = 1; r <= 4; r++) begin
      if (r == 4) begin
        run_to(k + 3 * (G + 2) + 50, p);
        continuous = 1'b0;
        checks++; if (p != 0) begin errors++; $display("FAIL cont_mid_valid got=%0d exp=0", p); end
      end
      run_to(k + r * (G + 2), p);
      checks++; if (valid !== 1'b1 || p != 0) begin errors++; $display("FAIL cont_valid_%0d got=%0b early=%0d exp=1/0", r, valid, p); end
      checks++; if (freq_cnt !== 27'd25) begin errors++; $display("FAIL cont_freq_%0d got=%0d exp=25", r, freq_cnt); end
    end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_stop_busy got=%0b exp=0", busy); end
    run_to(cyc + G + 10, p);
    checks++; if (p != 0) begin errors++; $display("FAIL cont_extra_valid got=%0d exp=0", p); end
  endtask

  task automatic test_reset_mid();
    int k, p;
    mode = 2; period = 10;
    pulse_start(k);
    run_to(k + 2 + 50, p);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL rmid_busy busy=%0b valid=%0b exp 0/0", busy, valid); end
    checks++; if (freq_cnt !== 27'd0 || ovf !== 1'b0) begin errors++; $display("FAIL rmid_freq got=%0d ovf=%0b exp=0/0", freq_cnt, ovf); end
    run_to(cyc + G + 10, p);
    checks++; if (p != 0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_quiet pulses=%0d busy=%0b exp 0/0", p, busy); end
    pulse_start(k);
    run_to(k + G + 2, p);
    checks++; if (valid !== 1'b1 || freq_cnt !== 27'd10) begin errors++; $display("FAIL rmid_restart valid=%0b freq=%0d exp 1/10", valid, freq_cnt); end
  endtask

  task automatic test_back_to_back();
    int k, p, j;
    mode = 2; period = 5;
    repeat (3) tick();
    pulse_start(k);
    run_to(k + 30, p);
    pulse_start(j);
    run_to(k + 80, p);
    pulse_start(j);
    run_to(k + G + 2, p);
    checks++; if (valid !== 1'b1 || p != 0) begin errors++; $display("FAIL b2b_valid got=%0b early=%0d exp=1/0", valid, p); end
    checks++; if (freq_cnt !== 27'd20) begin errors++; $display("FAIL b2b_freq got=%0d exp=20", freq_cnt); end
    run_to(cyc + G + 10, p);
    checks++; if (p != 0) begin errors++; $display("FAIL b2b_extra_valid got=%0d exp=0", p); end
    // start held high re-triggers from IDLE after each DONE
    k = cyc;
    start = 1'b1;
    run_to(k + G + 2, p);
    checks++; if (valid !== 1'b1 || p != 0) begin errors++; $display("FAIL held_valid1 got=%0b early=%0d exp=1/0", valid, p); end
    run_to(k + 2 * G + 5, p);
    start = 1'b0;
    checks++; if (valid !== 1'b1 || p != 0) begin errors++; $display("FAIL held_valid2 got=%0b early=%0d exp=1/0", valid, p); end
    checks++; if (freq_cnt !== 27'd20) begin errors++; $display("FAIL held_freq got=%0d exp=20", freq_cnt); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_idle busy=%0b exp=0", busy); end
  endtask

  task automatic test_random();
    int k, p, exp_n;
    mode = 3;
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(3, 20)) tick();
      pulse_start(k);
      run_to(k + G + 2, p);
      exp_n = model_count(k);
      checks++; if (valid !== 1'b1 || p != 0) begin errors++; $display("FAIL rnd%0d_valid got=%0b early=%0d exp=1/0", r, valid, p); end
      checks++; if (freq_cnt !== 27'(exp_n) || ovf !== 1'b0) begin errors++; $display("FAIL rnd%0d_freq got=%0d ovf=%0b exp=%0d/0", r, freq_cnt, ovf, exp_n); end
      checks++;
      if (freq4 !== 4'((exp_n > 15) ? 15 : exp_n) || ovf4 !== (exp_n > 15)) begin
        errors++;
        $display("FAIL rnd%0d_freq4 got=%0d ovf=%0b exp=%0d/%0b", r, freq4, ovf4, (exp_n > 15) ? 15 : exp_n, exp_n > 15);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; sig_in = 1'b0;
    v[0] = 1'b0;
    repeat (3) tick();
    test_reset();
    test_period10();
    test_toggle();
    test_constant();
    test_continuous();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
